// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the SNN layer sequencer:
//   - default parameter widths for the sequencer and its write-back delay line
//   - sequencer state encoding
//   - size_field(): extracts one NEU_W-wide layer-size field from the packed
//     layer_size configuration word (supports up to FLD_VEC_W packed bits)
// ---------------------------------------------------------------------------
package snn_pkg;

    localparam int DEF_NUM_LAYERS = 3;
    localparam int DEF_NEU_W      = 7;
    localparam int DEF_ADDR_W     = 9;
    localparam int DEF_W_ADDR_W   = 11;
    localparam int DEF_TS_W       = 8;
    localparam int DEF_NEU_LAT    = 2;

    // Widest packed layer_size vector the field helper accepts.
    localparam int FLD_VEC_W      = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_UPDATE  = 3'd3,
        ST_CLEAR   = 3'd4,
        ST_NEXT_TS = 3'd5,
        ST_DONE    = 3'd6
    } seq_state_e;

    // Field k of a packed vector of w-bit fields, zero-extended to 16 bits.
    function automatic logic [15:0] size_field(input logic [FLD_VEC_W-1:0] vec,
                                               input int k, input int w);
        return 16'((vec >> (k * w)) & ((64'd1 << w) - 64'd1));
    endfunction

endpackage

// File: rtl/snn_wb_delay.sv
// ---------------------------------------------------------------------------
// snn_wb_delay
// LAT-deep shift register of {valid, addr}. A potential/beta read issued in
// cycle t appears on out_vld/out_addr in cycle t+LAT, which is when the
// neuron pipeline result is ready to be written back.
// Ports:
//   clk, reset     clock, synchronous active-high reset (clears the line)
//   en             shift enable; low freezes every stage
//   in_vld/in_addr read-side valid and potential address
//   out_vld/out_addr delayed write-back valid and potential address
// ---------------------------------------------------------------------------
module snn_wb_delay #(
    parameter int LAT = 2,
    parameter int AW  = 9
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          in_vld,
    input  logic [AW-1:0] in_addr,
    output logic          out_vld,
    output logic [AW-1:0] out_addr
);

    logic [LAT-1:0]         vld_pipe;
    logic [LAT-1:0][AW-1:0] addr_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe  <= '0;
            addr_pipe <= '0;
        end else if (en) begin
            vld_pipe[0]  <= in_vld;
            addr_pipe[0] <= in_addr;
            for (int s = 1; s < LAT; s++) begin
                vld_pipe[s]  <= vld_pipe[s-1];
                addr_pipe[s] <= addr_pipe[s-1];
            end
        end
    end

    assign out_vld  = vld_pipe[LAT-1];
    assign out_addr = addr_pipe[LAT-1];

endmodule

// File: rtl/snn_layer_sequencer.sv
// ---------------------------------------------------------------------------
// snn_layer_sequencer
// Time-step / layer sequencer for the SNN accelerator. For each time step it
// walks layers 1..NUM_LAYERS; each layer runs an ACCUM phase (stream
// presynaptic spike and weight-row addresses into the accumulator bank) and an
// UPDATE phase (read current/potential/beta per neuron, write potential and
// spike back NEU_LAT cycles later), then clears the accumulators.
//
// Build option: define SEQ_STALL_EN to add the 'stall' input. While stall is
// high, state, counters and the write-back line hold, we/oen are forced low
// and addresses keep their values.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   [stall]               pause (SEQ_STALL_EN builds only)
//   start                 begin a run (sampled only in IDLE)
//   num_timesteps         time steps per run (latched at start)
//   layer_size            packed sizes, field k = layer k, k=0 input layer
//   busy, done            run in progress / one-cycle end-of-run pulse
//   time_step, layer      current position in the run
//   w_read_sram_addr      running weight-row address (ACCUM)
//   cntrl_ac_spk_read_addr presynaptic spike address (ACCUM)
//   cntrl_ac_reset        accumulator clear (CLEAR state, and during reset)
//   cntrl_ac_oen          accumulator output enable (UPDATE reads)
//   cntrl_u_select        neuron index being read
//   cntrl_potential_read_addr / cntrl_beta_read_addr
//   cntrl_potential_write_addr / cntrl_spk_write_addr and their we strobes
// ---------------------------------------------------------------------------
module snn_layer_sequencer
    import snn_pkg::*;
#(
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    parameter int NEU_W      = DEF_NEU_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int W_ADDR_W   = DEF_W_ADDR_W,
    parameter int TS_W       = DEF_TS_W,
    parameter int NEU_LAT    = DEF_NEU_LAT,
    localparam int LW        = $clog2(NUM_LAYERS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
`ifdef SEQ_STALL_EN
    input  logic                          stall,
`endif
    input  logic                          start,
    input  logic [TS_W-1:0]               num_timesteps,
    input  logic [(NUM_LAYERS+1)*NEU_W-1:0] layer_size,
    output logic                          busy,
    output logic                          done,
    output logic [TS_W-1:0]               time_step,
    output logic [LW-1:0]                 layer,
    output logic [W_ADDR_W-1:0]           w_read_sram_addr,
    output logic [ADDR_W-1:0]             cntrl_ac_spk_read_addr,
    output logic                          cntrl_ac_reset,
    output logic                          cntrl_ac_oen,
    output logic [NEU_W-1:0]              cntrl_u_select,
    output logic [ADDR_W-1:0]             cntrl_potential_read_addr,
    output logic [ADDR_W-1:0]             cntrl_beta_read_addr,
    output logic [ADDR_W-1:0]             cntrl_potential_write_addr,
    output logic [ADDR_W-1:0]             cntrl_spk_write_addr,
    output logic                          cntrl_potential_write_we,
    output logic                          cntrl_spk_write_we
);

    // Counter wide enough for size + NEU_LAT (max 2^NEU_W - 1 + 4).
    localparam int CW = NEU_W + 3;

    logic run_en;
`ifdef SEQ_STALL_EN
    assign run_en = ~stall;
`else
    assign run_en = 1'b1;
`endif

    seq_state_e                     state, state_n;
    logic [TS_W-1:0]                ts_q, ts_n, ts_max_q, ts_max_n;
    logic [LW-1:0]                  layer_q, layer_n, layer_m1;
    logic [CW-1:0]                  cnt_q, cnt_n;
    logic [W_ADDR_W-1:0]            row_q, row_n;
    logic [NUM_LAYERS:0][NEU_W-1:0] size_q, size_n, size_in;
    logic [NUM_LAYERS:0][ADDR_W-1:0] offs;
    logic [NEU_W-1:0]               sz_cur, sz_prev;
    logic [ADDR_W-1:0]              off_cur, off_prev;

    for (genvar k = 0; k <= NUM_LAYERS; k++) begin : g_fld
        assign size_in[k] = NEU_W'(size_field(FLD_VEC_W'(layer_size), k, NEU_W));
    end

    // S_k = sum of latched sizes below layer k.
    always_comb begin
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int k = 0; k <= NUM_LAYERS; k++) begin
            offs[k] = acc;
            acc     = acc + ADDR_W'(size_q[k]);
        end
    end

    assign layer_m1 = layer_q - LW'(1);
    assign sz_cur   = size_q[layer_q];
    assign sz_prev  = size_q[layer_m1];
    assign off_cur  = offs[layer_q];
    assign off_prev = offs[layer_m1];

    // ---------------- next-state / counter logic ----------------
    always_comb begin
        state_n  = state;
        ts_n     = ts_q;
        ts_max_n = ts_max_q;
        layer_n  = layer_q;
        cnt_n    = cnt_q;
        row_n    = row_q;
        size_n   = size_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    ts_max_n = num_timesteps;
                    size_n   = size_in;
                    ts_n     = '0;
                    layer_n  = LW'(1);
                    cnt_n    = '0;
                    row_n    = '0;
                    state_n  = (num_timesteps == '0) ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_n   = '0;
                state_n = (sz_cur == '0 || sz_prev == '0) ? ST_CLEAR : ST_ACCUM;
            end
            ST_ACCUM: begin
                cnt_n = cnt_q + CW'(1);
                row_n = row_q + W_ADDR_W'(1);   // wraps silently
                if (cnt_q == CW'(sz_prev) - CW'(1)) begin
                    cnt_n   = '0;
                    state_n = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                cnt_n = cnt_q + CW'(1);
                // Reads occupy the first sz_cur cycles; the tail lets the
                // last NEU_LAT write-backs drain.
                if (cnt_q == CW'(sz_cur) + CW'(NEU_LAT - 1)) begin
                    cnt_n   = '0;
                    state_n = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (layer_q < LW'(NUM_LAYERS)) begin
                    layer_n = layer_q + LW'(1);
                    state_n = ST_SETUP;
                end else begin
                    state_n = ST_NEXT_TS;
                end
            end
            ST_NEXT_TS: begin
                ts_n    = ts_q + TS_W'(1);
                layer_n = LW'(1);
                row_n   = '0;               // weight rows restart each step
                state_n = (ts_n == ts_max_q) ? ST_DONE : ST_SETUP;
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            ts_q     <= '0;
            ts_max_q <= '0;
            layer_q  <= '0;
            cnt_q    <= '0;
            row_q    <= '0;
            size_q   <= '0;
        end else if (run_en) begin
            state    <= state_n;
            ts_q     <= ts_n;
            ts_max_q <= ts_max_n;
            layer_q  <= layer_n;
            cnt_q    <= cnt_n;
            row_q    <= row_n;
            size_q   <= size_n;
        end
    end

    // ---------------- datapath strobes / addresses ----------------
    logic              acc_act, rd_vld, wb_vld;
    logic [ADDR_W-1:0] pot_rd, wb_addr;

    assign acc_act = (state == ST_ACCUM);
    assign rd_vld  = (state == ST_UPDATE) && (cnt_q < CW'(sz_cur));
    assign pot_rd  = rd_vld ? (off_cur - ADDR_W'(size_q[0]) + ADDR_W'(cnt_q)) : '0;

    snn_wb_delay #(
        .LAT (NEU_LAT),
        .AW  (ADDR_W)
    ) u_wb_delay (
        .clk      (clk),
        .reset    (reset),
        .en       (run_en),
        .in_vld   (rd_vld),
        .in_addr  (pot_rd),
        .out_vld  (wb_vld),
        .out_addr (wb_addr)
    );

    assign busy                   = (state != ST_IDLE);
    assign done                   = (state == ST_DONE);
    assign time_step              = ts_q;
    assign layer                  = layer_q;
    assign w_read_sram_addr       = acc_act ? row_q : '0;
    assign cntrl_ac_spk_read_addr = acc_act ? (off_prev + ADDR_W'(cnt_q)) : '0;
    assign cntrl_ac_reset         = reset | (state == ST_CLEAR);
    assign cntrl_ac_oen           = rd_vld & run_en;
    assign cntrl_u_select         = rd_vld ? cnt_q[NEU_W-1:0] : '0;
    assign cntrl_potential_read_addr = pot_rd;
    assign cntrl_beta_read_addr      = pot_rd;
    // Spike address S_l+n equals potential address (S_l-size0+n) + size0.
    assign cntrl_potential_write_addr = wb_vld ? wb_addr : '0;
    assign cntrl_spk_write_addr       = wb_vld ? (wb_addr + ADDR_W'(size_q[0])) : '0;
    assign cntrl_potential_write_we   = wb_vld & run_en;
    assign cntrl_spk_write_we         = wb_vld & run_en;

endmodule

// File: doc/snn_layer_sequencer.md
Name: snn_layer_sequencer

Overview:
Parametrised time-step/layer sequencer for the SNN accelerator; generalises the fixed 64-neuron/512-cycle hidden-layer controller to NUM_LAYERS layers of runtime-programmable size and a programmable number of time steps.
- For every time step, walks each layer in two phases.
- ACCUM streams presynaptic spike addresses and weight-row addresses into the accumulator bank.
- UPDATE reads accumulated current, potential and beta per neuron, then writes potential and spike back after the neuron pipeline latency.
- Sits between the host start/done handshake and the SRAM/accumulator/neuron datapath.

Parameters:
- NUM_LAYERS, 3, number of computed layers (input layer excluded).
- NEU_W, 7, width of one layer-size field; sizes 0..2^NEU_W-1.
- ADDR_W, 9, spike/potential/beta SRAM address width.
- W_ADDR_W, 11, weight SRAM address width.
- TS_W, 8, time-step counter width.
- NEU_LAT, 2, cycles from potential read address to write-back address (range 1..4).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  begin run; sampled only in IDLE.
- num_timesteps  in  TS_W  time steps per run; latched at start.
- layer_size  in  (NUM_LAYERS+1)*NEU_W  field k = size of layer k (k=0 is input); latched at start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse at end of run.
- time_step  out  TS_W  current time step.
- layer  out  $clog2(NUM_LAYERS+1)  current layer, 1..NUM_LAYERS.
- w_read_sram_addr  out  W_ADDR_W  weight-row address.
- cntrl_ac_spk_read_addr  out  ADDR_W  presynaptic spike address.
- cntrl_ac_reset  out  1  accumulator clear pulse.
- cntrl_ac_oen  out  1  accumulator output enable.
- cntrl_u_select  out  NEU_W  neuron index being read.
- cntrl_potential_read_addr, cntrl_beta_read_addr  out  ADDR_W  each.
- cntrl_potential_write_addr, cntrl_spk_write_addr  out  ADDR_W  each.
- cntrl_potential_write_we, cntrl_spk_write_we  out  1  each.

Behaviour:
- Reset: state IDLE. All outputs 0. cntrl_ac_reset = 1 for the reset cycle only.
- Offsets: S_k = sum of size[j] for j<k, computed combinationally from the latched sizes.
- Layer l reads spikes at S_{l-1}+i for i < size[l-1]. It writes spikes at S_l+n. Potential/beta address = S_l - size[0] + n.
- States: IDLE -> SETUP -> ACCUM -> UPDATE -> CLEAR -> (SETUP of next layer | NEXT_TS) -> (SETUP | DONE) -> IDLE.
- IDLE: start=1 latches the config, sets time_step=0 and layer=1, and enters SETUP.
  - If num_timesteps=0, go straight to DONE instead.
  - start while not IDLE is ignored.
- SETUP (1 cycle): load the layer's address counters; i=0.
  - If size[l]=0 or size[l-1]=0, skip to CLEAR without asserting we or oen.
- ACCUM: size[l-1] cycles. Each cycle presents cntrl_ac_spk_read_addr = S_{l-1}+i and w_read_sram_addr = running row counter; both increment.
  - The row counter resets to 0 at each new time step; it is not reset per layer.
  - W_ADDR_W overflow wraps silently.
- UPDATE: size[l]+NEU_LAT cycles.
  - For n < size[l]: cntrl_ac_oen=1, cntrl_u_select=n, potential/beta read addr valid.
  - Writes are delayed NEU_LAT cycles from the matching read; both we strobes are high for exactly size[l] cycles.
- CLEAR (1 cycle): cntrl_ac_reset=1, we=0.
  - If l < NUM_LAYERS: l increments, go to SETUP.
  - Otherwise go to NEXT_TS.
- NEXT_TS: time_step increments and l=1.
  - If the new time_step == num_timesteps, go to DONE; else go to SETUP.
- DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE.
- Read-to-write delay uses a NEU_LAT-deep shift register of (valid, addr).
- reset mid-run aborts immediately; write enables must be 0 in the cycle after reset is asserted.

Optional Feature:
- Macro SEQ_STALL_EN adds input port stall (1 bit).
- With it: while stall=1, state, counters and the delay pipeline hold; we/oen are forced to 0, and addresses hold their values.
- Without it: the port is absent and the sequencer never pauses.

Decomposition:
- Shared package snn_pkg holds the state encoding constants, the default widths, and the field-extract helper for layer_size.
- One sub-module, snn_wb_delay: parametrised NEU_LAT shift register of {valid, addr} producing the write-back address and we.

Test Plan:
- Sizes {8,4,2,1}, num_timesteps=1, start -> ACCUM lengths 8/4/2 and UPDATE we-high counts 4/2/1.
  - Spike writes at 8..11, 12..13, 14; potential writes at 0..3, 4..5, 6.
  - w_read_sram_addr runs 0..13; done exactly once.
- Same config, num_timesteps=3 -> three identical layer sweeps; time_step 0,1,2; the weight row counter restarts at 0 each step.
- size[2]=0 -> layers 2 and 3 skipped with no we/oen; cntrl_ac_reset pulses still occur; done still fires.
- num_timesteps=0 -> done pulses within 2 cycles of start; no we or oen ever asserted.
- reset asserted in mid-UPDATE of layer 2 -> next cycle all we=0, state IDLE.
  - A fresh start then reproduces scenario 1 exactly.
- With SEQ_STALL_EN: stall held 5 cycles mid-ACCUM -> addresses frozen and total run length exactly 5 cycles longer; write sequence identical.
